// File: rtl/dense_sched_10_pkg.sv
// Shared constants and state encoding for the dense layer scheduler.
package dense_sched_10_pkg;

    localparam int N_LEN           = 16;
    localparam int F_LEN           = 8;
    localparam int DENSE_INNER_LAT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Cycles from a read strobe until the inner pipeline presents its product sum.
    function automatic int tag_depth(input int mem_lat);
        return mem_lat + DENSE_INNER_LAT;
    endfunction

endpackage

// File: rtl/dense_sched_tag_pipe.sv
// Fixed-latency tag shift register; the MSB of each word is its valid bit.
module dense_sched_tag_pipe #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             pend_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per cycle, flushed by the synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    // pend_o ignores the output stage so the caller can see "empty after this cycle".
    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pend_o = pend_o | stage_q[i][WIDTH-1];
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dense_sched_10.sv
// Issues chunk reads for a dense layer and accumulates per-neuron partial sums.
module dense_sched_10
    import dense_sched_10_pkg::*;
#(
    parameter int DATA_WIDTH = N_LEN,
    parameter int MAX_CHUNK  = 16,
    parameter int MAX_OUT    = 64,
    parameter int MEM_LAT    = 1,
    parameter int CW = $clog2(MAX_CHUNK + 1),
    parameter int OW = $clog2(MAX_OUT + 1),
    parameter int AW = $clog2(MAX_CHUNK * MAX_OUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CW-1:0]         cfg_n_chunk,
    input  logic [OW-1:0]         cfg_n_out,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [CW-1:0]         in_addr,
    output logic [AW-1:0]         w_addr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  out_valid,
    output logic [OW-1:0]         out_idx,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int L  = tag_depth(MEM_LAT);
    localparam int TW = 3 + OW;

    state_t                state_q, state_d;
    logic [CW-1:0]         n_chunk_q, chunk_q, in_addr_q;
    logic [OW-1:0]         n_out_q, nrn_q, tag_idx_q, out_idx_q;
    logic [AW-1:0]         wcnt_q, w_addr_q;
    logic                  rd_en_q, tag_first_q, tag_last_q;
    logic                  busy_q, done_q, out_valid_q;
    logic [DATA_WIDTH-1:0] acc_q, out_data_q, sum_s;
    logic                  issue_s, chunk_last_s, layer_last_s, cfg_zero_s, pend_s;
    logic [TW-1:0]         pipe_in_s, pipe_out_s;

    assign issue_s      = (state_q == S_RUN) && !hold;
    assign chunk_last_s = (chunk_q == n_chunk_q - CW'(1));
    assign layer_last_s = chunk_last_s && (nrn_q == n_out_q - OW'(1));
    assign cfg_zero_s   = (cfg_n_chunk == CW'(0)) || (cfg_n_out == OW'(0));
    assign sum_s        = acc_q + q;
    assign pipe_in_s    = {rd_en_q, tag_first_q, tag_last_q, tag_idx_q};

    dense_sched_tag_pipe #(
        .DEPTH (L),
        .WIDTH (TW)
    ) u_tag_pipe (
        .clk_i  (clk),
        .clr_i  (rst),
        .d_i    (pipe_in_s),
        .q_o    (pipe_out_s),
        .pend_o (pend_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; DRAIN leaves once the final tag is at the pipe output.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = cfg_zero_s ? S_DONE : S_RUN;
                else       state_d = S_IDLE;
            end
            S_RUN: begin
                if (issue_s && layer_last_s) state_d = S_DRAIN;
                else                         state_d = S_RUN;
            end
            S_DRAIN: begin
                if (!rd_en_q && !pend_s) state_d = S_DONE;
                else                     state_d = S_DRAIN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Issue counters, registered read/tag strobes and the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_chunk_q   <= '0;
            n_out_q     <= '0;
            chunk_q     <= '0;
            nrn_q       <= '0;
            wcnt_q      <= '0;
            rd_en_q     <= 1'b0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            tag_first_q <= 1'b0;
            tag_last_q  <= 1'b0;
            tag_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            acc_q       <= '0;
        end else begin
            busy_q      <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q      <= (state_q == S_DONE);
            rd_en_q     <= issue_s;
            out_valid_q <= pipe_out_s[TW-1] && pipe_out_s[TW-3];
            if ((state_q == S_IDLE) && start) begin
                n_chunk_q <= cfg_n_chunk;
                n_out_q   <= cfg_n_out;
                chunk_q   <= '0;
                nrn_q     <= '0;
                wcnt_q    <= '0;
            end
            if (issue_s) begin
                in_addr_q   <= chunk_q;
                w_addr_q    <= wcnt_q;
                tag_first_q <= (chunk_q == CW'(0));
                tag_last_q  <= chunk_last_s;
                tag_idx_q   <= nrn_q;
                wcnt_q      <= wcnt_q + AW'(1);
                if (chunk_last_s) begin
                    chunk_q <= '0;
                    nrn_q   <= nrn_q + OW'(1);
                end else begin
                    chunk_q <= chunk_q + CW'(1);
                end
            end
            // q is only meaningful while the aligned tag is valid.
            if (pipe_out_s[TW-1]) begin
                acc_q <= pipe_out_s[TW-2] ? q : sum_s;
                if (pipe_out_s[TW-3]) begin
                    out_data_q <= pipe_out_s[TW-2] ? q : sum_s;
                    out_idx_q  <= pipe_out_s[OW-1:0];
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign in_addr   = in_addr_q;
    assign w_addr    = w_addr_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule
